// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing,
// pattern mode encodings and the colour-bar table.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_COLOR_W = 3;
  localparam int DEF_SYNC_ACT_LOW = 1;
  localparam int DEF_CHECK_LOG2 = 5;
  localparam int DEF_GRAD_SHIFT = 6;

  typedef enum logic [2:0] {
    MODE_BLACK    = 3'd0,
    MODE_RED      = 3'd1,
    MODE_GREEN    = 3'd2,
    MODE_BLUE     = 3'd3,
    MODE_CHECKER  = 3'd4,
    MODE_BARS     = 3'd5,
    MODE_GRADIENT = 3'd6,
    MODE_BORDER   = 3'd7
  } mode_e;

  // {r,g,b} on/off mask for each bar, left to right
  function automatic logic [2:0] bar_mask(
    input logic [2:0] idx
  );
    logic [2:0] m;
    case (idx)
      3'd0: m = 3'b111;
      3'd1: m = 3'b110;
      3'd2: m = 3'b011;
      3'd3: m = 3'b010;
      3'd4: m = 3'b101;
      3'd5: m = 3'b100;
      3'd6: m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Column/row raster counters with sync and visible decode.
// Decode outputs are combinational views of the counters.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COL_W = $clog2(H_TOTAL),
  localparam int ROW_W = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame_start
);

  localparam logic [COL_W-1:0] H_LAST =
    COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST =
    ROW_W'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (col == H_LAST) begin
      col <= '0;
      if (row == V_LAST)
        row <= '0;
      else
        row <= row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  // Compare as int so a sync edge at H_TOTAL cannot wrap
  always_comb begin
    hsync = (int'(col) >= HS_START) &&
            (int'(col) < HS_END);
    vsync = (int'(row) >= VS_START) &&
            (int'(row) < VS_END);
    active = (int'(col) < H_ACTIVE) &&
             (int'(row) < V_ACTIVE);
    frame_start = (col == '0) && (row == '0);
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing plus eight frame-synchronous test patterns.
// Sync, colour and position leave on one register stage.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int SYNC_ACT_LOW = DEF_SYNC_ACT_LOW,
  parameter int CHECK_LOG2 = DEF_CHECK_LOG2,
  parameter int GRAD_SHIFT = DEF_GRAD_SHIFT,
  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COL_W = $clog2(H_TOTAL),
  localparam int ROW_W = $clog2(V_TOTAL)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         i_Mode,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Active,
  output logic               o_Frame_Start,
  output logic [COL_W-1:0]   o_Col,
  output logic [ROW_W-1:0]   o_Row,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue
);

  localparam logic SYNC_IDLE = (SYNC_ACT_LOW != 0);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int FULL_I = (2 ** COLOR_W) - 1;
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [COL_W-1:0] s0_col;
  logic [ROW_W-1:0] s0_row;
  logic s0_hs;
  logic s0_vs;
  logic s0_act;
  logic s0_fs;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk         (CLK),
    .rst         (RST),
    .col         (s0_col),
    .row         (s0_row),
    .hsync       (s0_hs),
    .vsync       (s0_vs),
    .active      (s0_act),
    .frame_start (s0_fs)
  );

  mode_e r_mode;
  mode_e eff_mode;

  // Pixel (0,0) already uses the mode being latched
  assign eff_mode =
    s0_fs ? mode_e'(i_Mode) : r_mode;

  always_ff @(posedge CLK) begin
    if (RST)
      r_mode <= MODE_BLACK;
    else if (s0_fs)
      r_mode <= mode_e'(i_Mode);
  end

  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;
  logic [COL_W-1:0] grad_raw;
  logic [COLOR_W-1:0] grey;
  logic tile;
  logic edge_px;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (int'(s0_col) >= k * BAR_W)
        bar_idx = bar_idx + 3'd1;
    bar_rgb = bar_mask(bar_idx);

    grad_raw = s0_col >> GRAD_SHIFT;
    if (int'(grad_raw) > FULL_I)
      grey = FULL;
    else
      grey = COLOR_W'(grad_raw);

    tile = s0_col[CHECK_LOG2] ^ s0_row[CHECK_LOG2];
    edge_px = (s0_col == '0) ||
              (int'(s0_col) == H_ACTIVE - 1) ||
              (s0_row == '0) ||
              (int'(s0_row) == V_ACTIVE - 1);

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (s0_act) begin
      unique case (eff_mode)
        MODE_BLACK: ;
        MODE_RED: pix_r = FULL;
        MODE_GREEN: pix_g = FULL;
        MODE_BLUE: pix_b = FULL;
        MODE_CHECKER: begin
          pix_r = {COLOR_W{tile}};
          pix_g = {COLOR_W{tile}};
          pix_b = {COLOR_W{tile}};
        end
        MODE_BARS: begin
          pix_r = {COLOR_W{bar_rgb[2]}};
          pix_g = {COLOR_W{bar_rgb[1]}};
          pix_b = {COLOR_W{bar_rgb[0]}};
        end
        MODE_GRADIENT: begin
          pix_r = grey;
          pix_g = grey;
          pix_b = grey;
        end
        MODE_BORDER: begin
          pix_r = {COLOR_W{edge_px}};
          pix_g = {COLOR_W{edge_px}};
          pix_b = {COLOR_W{edge_px}};
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      o_HSync <= SYNC_IDLE;
      o_VSync <= SYNC_IDLE;
      o_Active <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Col <= '0;
      o_Row <= '0;
      o_Red <= '0;
      o_Green <= '0;
      o_Blue <= '0;
    end else begin
      o_HSync <= s0_hs ^ SYNC_IDLE;
      o_VSync <= s0_vs ^ SYNC_IDLE;
      o_Active <= s0_act;
      o_Frame_Start <= s0_fs;
      o_Col <= s0_col;
      o_Row <= s0_row;
      o_Red <= pix_r;
      o_Green <= pix_g;
      o_Blue <= pix_b;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen on a reduced raster,
// one active-low 3-bit instance and one active-high 4-bit.
module tb_vga_timing_pattern_gen;

  localparam int HA = 64;
  localparam int HFP = 4;
  localparam int HS = 8;
  localparam int HBP = 4;
  localparam int VA = 12;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VBP = 3;
  localparam int CL = 2;
  localparam int GS = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
    logic [6:0] col;
    logic [4:0] row;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } obs_t;

  typedef struct {
    int mode;
    int col;
    int row;
    int r;
    int g;
    int b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] mode;

  logic hs1, vs1, act1, fs1;
  logic [6:0] col1;
  logic [4:0] row1;
  logic [2:0] r1, g1, b1;
  logic hs2, vs2, act2, fs2;
  logic [6:0] col2;
  logic [4:0] row2;
  logic [3:0] r2, g2, b2;

  vga_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP),
    .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP),
    .V_SYNC (VS), .V_BP (VBP),
    .COLOR_W (3), .SYNC_ACT_LOW (1),
    .CHECK_LOG2 (CL), .GRAD_SHIFT (GS)
  ) dut1 (
    .CLK (clk), .RST (rst), .i_Mode (mode),
    .o_HSync (hs1), .o_VSync (vs1),
    .o_Active (act1), .o_Frame_Start (fs1),
    .o_Col (col1), .o_Row (row1),
    .o_Red (r1), .o_Green (g1), .o_Blue (b1)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP),
    .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP),
    .V_SYNC (VS), .V_BP (VBP),
    .COLOR_W (4), .SYNC_ACT_LOW (0),
    .CHECK_LOG2 (CL), .GRAD_SHIFT (GS)
  ) dut2 (
    .CLK (clk), .RST (rst), .i_Mode (mode),
    .o_HSync (hs2), .o_VSync (vs2),
    .o_Active (act2), .o_Frame_Start (fs2),
    .o_Col (col2), .o_Row (row2),
    .o_Red (r2), .o_Green (g2), .o_Blue (b2)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pos = 0;
  int fmode = 0;
  obs_t got1, got2;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               nm, cyc, got, exp);
    end
  endtask

  function automatic obs_t rst_obs(input bit lo);
    obs_t o;
    o = '0;
    o.hs = lo;
    o.vs = lo;
    return o;
  endfunction

  // Reference pixel: raster index p, frame mode m
  function automatic obs_t model(input int m,
                                 input int p,
                                 input int cw,
                                 input bit lo);
    obs_t o;
    int c, rw, full, lvl, br;
    bit hon, von, on;
    int bars[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int rr, gg, bb;
    c = p % HT;
    rw = p / HT;
    full = (1 << cw) - 1;
    hon = (c >= HA + HFP) && (c < HA + HFP + HS);
    von = (rw >= VA + VFP) && (rw < VA + VFP + VS);
    o = '0;
    o.col = 7'(c);
    o.row = 5'(rw);
    o.hs = lo ? !hon : hon;
    o.vs = lo ? !von : von;
    o.fs = (p == 0);
    o.act = (c < HA) && (rw < VA);
    rr = 0;
    gg = 0;
    bb = 0;
    if (o.act) begin
      case (m)
        1: rr = full;
        2: gg = full;
        3: bb = full;
        4: begin
          on = (((c >> CL) ^ (rw >> CL)) & 1) != 0;
          rr = on ? full : 0;
          gg = rr;
          bb = rr;
        end
        5: begin
          br = bars[c / (HA / 8)];
          rr = br[2] ? full : 0;
          gg = br[1] ? full : 0;
          bb = br[0] ? full : 0;
        end
        6: begin
          lvl = c >> GS;
          if (lvl > full) lvl = full;
          rr = lvl;
          gg = lvl;
          bb = lvl;
        end
        7: begin
          on = (c == 0) || (c == HA - 1) ||
               (rw == 0) || (rw == VA - 1);
          rr = on ? full : 0;
          gg = rr;
          bb = rr;
        end
        default: ;
      endcase
    end
    o.r = 4'(rr);
    o.g = 4'(gg);
    o.b = 4'(bb);
    return o;
  endfunction

  task automatic tick();
    obs_t e1, e2;
    if (rst) begin
      e1 = rst_obs(1'b1);
      e2 = rst_obs(1'b0);
      pos = 0;
    end else begin
      if (pos == 0) fmode = int'(mode);
      e1 = model(fmode, pos, 3, 1'b1);
      e2 = model(fmode, pos, 4, 1'b0);
      pos = (pos + 1) % FR;
    end
    @(posedge clk);
    #1;
    cyc++;
    got1 = {hs1, vs1, act1, fs1, col1, row1,
            1'b0, r1, 1'b0, g1, 1'b0, b1};
    got2 = {hs2, vs2, act2, fs2, col2, row2,
            r2, g2, b2};
    chk("dut1_px", 64'(got1), 64'(e1));
    chk("dut2_px", 64'(got2), 64'(e2));
  endtask

  task automatic goto_pre(input int target);
    for (int i = 0; i <= FR && pos != target; i++)
      tick();
    chk("goto_bound", 64'(pos), 64'(target));
  endtask

  task automatic show(input int c, input int rw);
    goto_pre(rw * HT + c);
    tick();
  endtask

  task automatic frame_stats();
    int hs_low = 0, act_n = 0, vs_low = 0;
    int fs_n = 0, bad_run = 0, bad_gap = 0;
    int run = 0, last = -1, fcol = -1;
    int vcol = -1, vrow = -1;
    logic phs = 1'b1, pvs = 1'b1;
    mode = 3'd5;
    goto_pre(0);
    for (int i = 0; i < FR; i++) begin
      tick();
      if (!hs1) begin
        hs_low++;
        run++;
      end
      if (phs && !hs1) begin
        if (fcol < 0) fcol = int'(col1);
        if (last >= 0 && i - last != HT)
          bad_gap++;
        last = i;
      end
      if (!phs && hs1) begin
        if (run != HS) bad_run++;
        run = 0;
      end
      if (!vs1) vs_low++;
      if (pvs && !vs1) begin
        vcol = int'(col1);
        vrow = int'(row1);
      end
      act_n += int'(act1);
      fs_n += int'(fs1);
      phs = hs1;
      pvs = vs1;
    end
    chk("hs_low_total", 64'(hs_low), 64'(VT * HS));
    chk("hs_fall_col", 64'(fcol), 64'(HA + HFP));
    chk("hs_run_len", 64'(bad_run), 64'(0));
    chk("hs_period", 64'(bad_gap), 64'(0));
    chk("active_total", 64'(act_n), 64'(HA * VA));
    chk("vs_low_total", 64'(vs_low), 64'(VS * HT));
    chk("vs_fall_row", 64'(vrow), 64'(VA + VFP));
    chk("vs_fall_col", 64'(vcol), 64'(0));
    chk("fs_per_frame", 64'(fs_n), 64'(1));
    tick();
    chk("fs_period", 64'(fs1), 64'(1));
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{5, 0, 3, 7, 7, 7},
      '{5, 8, 3, 7, 7, 0},
      '{5, 16, 3, 0, 7, 7},
      '{5, 48, 3, 0, 0, 7},
      '{5, 56, 3, 0, 0, 0},
      '{5, 63, 3, 0, 0, 0},
      '{5, 70, 3, 0, 0, 0},
      '{4, 4, 0, 7, 7, 7},
      '{4, 4, 4, 0, 0, 0},
      '{4, 0, 4, 7, 7, 7},
      '{4, 0, 8, 0, 0, 0},
      '{6, 4, 2, 1, 1, 1},
      '{6, 20, 2, 5, 5, 5},
      '{6, 63, 2, 7, 7, 7},
      '{7, 0, 6, 7, 7, 7},
      '{7, 32, 11, 7, 7, 7},
      '{7, 32, 6, 0, 0, 0},
      '{7, 63, 6, 7, 7, 7},
      '{1, 10, 3, 7, 0, 0},
      '{2, 5, 5, 0, 7, 0},
      '{3, 5, 5, 0, 0, 7},
      '{0, 10, 3, 0, 0, 0}
    };

    rst = 1'b1;
    mode = 3'd0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_state1",
        64'({hs1, vs1, act1, fs1, r1, g1, b1}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 9'd0}));
    chk("rst_state2",
        64'({hs2, vs2, act2, r2, g2, b2}),
        64'({1'b0, 1'b0, 1'b0, 12'd0}));
    rst = 1'b0;
    tick();
    chk("first_fs", 64'(fs1), 64'(1));
    chk("first_pos", 64'({col1, row1}), 64'(0));

    frame_stats();

    foreach (tbl[i]) begin
      if (tbl[i].mode != fmode) begin
        mode = 3'(tbl[i].mode);
        goto_pre(0);
        tick();
      end
      show(tbl[i].col, tbl[i].row);
      chk($sformatf("vec%0d_m%0d", i, tbl[i].mode),
          64'({r1, g1, b1}),
          64'({3'(tbl[i].r), 3'(tbl[i].g),
               3'(tbl[i].b)}));
    end

    mode = 3'd5;
    goto_pre(0);
    tick();
    show(0, 5);
    mode = 3'd1;
    show(0, 8);
    chk("midframe_hold", 64'({r1, g1, b1}),
        64'(9'o777));
    goto_pre(0);
    tick();
    show(0, 8);
    chk("next_frame_red", 64'({r1, g1, b1}),
        64'(9'o700));
    chk("red_cw4", 64'({r2, g2, b2}),
        64'(12'hF00));

    goto_pre((VA + VFP) * HT + HA + HFP + 2);
    tick();
    chk("pre_rst_syncs", 64'({hs1, vs1}), 64'(0));
    rst = 1'b1;
    tick();
    chk("mid_rst_syncs", 64'({hs1, vs1, fs1}),
        64'(3'b110));
    rst = 1'b0;
    tick();
    chk("mid_rst_fs", 64'(fs1), 64'(1));

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0)
        mode = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
